// File: rtl/dmem_resp_pkg.sv
// Shared types and constants for the data-memory responder.
// Byte-enable legality here is only consulted when DMEM_ERR_EN is defined.
package dmem_resp_pkg;

  localparam int DEF_ADDR_WIDTH = 32;
  localparam int DEF_DATA_WIDTH = 32;
  localparam int BE_WIDTH       = 4;

  typedef enum logic [1:0] {
    DMEM_IDLE = 2'd0,
    DMEM_WAIT = 2'd1,
    DMEM_RESP = 2'd2
  } dmem_state_e;

  localparam logic [BE_WIDTH-1:0] BE_B0 = 4'b0001;
  localparam logic [BE_WIDTH-1:0] BE_B1 = 4'b0010;
  localparam logic [BE_WIDTH-1:0] BE_B2 = 4'b0100;
  localparam logic [BE_WIDTH-1:0] BE_B3 = 4'b1000;
  localparam logic [BE_WIDTH-1:0] BE_H0 = 4'b0011;
  localparam logic [BE_WIDTH-1:0] BE_H1 = 4'b1100;
  localparam logic [BE_WIDTH-1:0] BE_W  = 4'b1111;

  // Naturally aligned byte, halfword or word only.
  function automatic logic be_legal(input logic [BE_WIDTH-1:0] be);
    return be inside {BE_B0, BE_B1, BE_B2, BE_B3, BE_H0, BE_H1, BE_W};
  endfunction

endpackage

// File: rtl/dmem_resp_ram.sv
// Single-port byte-writable synchronous word array; no reset on contents.
// Read returns the pre-write word on a store cycle; the responder masks it.
module dmem_resp_ram
  import dmem_resp_pkg::*;
#(
  parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int DEPTH_WORDS = 1024,
  parameter int IDX_W       = $clog2(DEPTH_WORDS)
) (
  input  logic                  clk_i,
  input  logic                  en,
  input  logic                  we,
  input  logic [BE_WIDTH-1:0]   be,
  input  logic [IDX_W-1:0]      index,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata
);

  localparam int LANE_W = DATA_WIDTH / BE_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH_WORDS];

  always_ff @(posedge clk_i) begin
    if (en) begin
      if (we) begin
        for (int b = 0; b < BE_WIDTH; b++) begin
          if (be[b]) mem[index][b*LANE_W +: LANE_W] <= wdata[b*LANE_W +: LANE_W];
        end
      end
      rdata <= mem[index];
    end
  end

endmodule

// File: rtl/dmem_resp.sv
// Data-memory responder: one request per handshake, fixed wait states, one-cycle response.
// Optional access checking (range and byte-enable shape) is enabled by DMEM_ERR_EN.
module dmem_resp
  import dmem_resp_pkg::*;
#(
  parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_CYCLES = 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  req_i,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic [BE_WIDTH-1:0]   be_i,
  output logic                  gnt_o,
  output logic                  rvalid_o,
  output logic [DATA_WIDTH-1:0] rdata_o,
  output logic                  err_o,
  output logic                  busy_o
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);

  dmem_state_e           state;
  logic [3:0]            cnt;
  logic                  lat_we;
  logic [ADDR_WIDTH-1:0] lat_addr;
  logic [DATA_WIDTH-1:0] lat_wdata;
  logic [BE_WIDTH-1:0]   lat_be;

  logic                  accept, acc_fire, acc_we, acc_err;
  logic [ADDR_WIDTH-1:0] acc_addr;
  logic [DATA_WIDTH-1:0] acc_wdata, ram_rdata;
  logic [BE_WIDTH-1:0]   acc_be;
  logic                  zero_q, err_q;
  logic                  unused_bits;

  assign gnt_o  = (state != DMEM_WAIT);
  assign busy_o = (state != DMEM_IDLE);
  assign accept = req_i && gnt_o;

  // With no wait states the access commits on the accept edge, straight from the inputs.
  assign acc_we    = (WAIT_CYCLES == 0) ? we_i    : lat_we;
  assign acc_addr  = (WAIT_CYCLES == 0) ? addr_i  : lat_addr;
  assign acc_wdata = (WAIT_CYCLES == 0) ? wdata_i : lat_wdata;
  assign acc_be    = (WAIT_CYCLES == 0) ? be_i    : lat_be;
  assign acc_fire  = (state == DMEM_WAIT && cnt == 4'd0) || (WAIT_CYCLES == 0 && accept);

`ifdef DMEM_ERR_EN
  assign acc_err = ((acc_addr >> (IDX_W + 2)) != '0) || !be_legal(acc_be);
`else
  assign acc_err = 1'b0;
`endif
  assign unused_bits = ^{acc_addr[1:0], acc_addr[ADDR_WIDTH-1:IDX_W+2]};

  dmem_resp_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH_WORDS(DEPTH_WORDS),
    .IDX_W      (IDX_W)
  ) u_ram (
    .clk_i(clk_i),
    .en   (acc_fire && !rst_i),
    .we   (acc_we && !acc_err),
    .be   (acc_be),
    .index(acc_addr[IDX_W+1:2]),
    .wdata(acc_wdata),
    .rdata(ram_rdata)
  );

  // Stores and errored accesses report zero data; the value holds until the next access.
  assign rdata_o = zero_q ? '0 : ram_rdata;
  assign err_o   = err_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state     <= DMEM_IDLE;
      cnt       <= 4'd0;
      rvalid_o  <= 1'b0;
      zero_q    <= 1'b1;
      err_q     <= 1'b0;
      lat_we    <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      lat_be    <= '0;
    end else begin
      rvalid_o <= acc_fire;
      if (acc_fire) begin
        zero_q <= acc_we || acc_err;
        err_q  <= acc_err;
      end
      case (state)
        DMEM_WAIT: begin
          if (cnt == 4'd0) state <= DMEM_RESP;
          else             cnt   <= cnt - 4'd1;
        end
        default: begin
          if (accept) begin
            lat_we    <= we_i;
            lat_addr  <= addr_i;
            lat_wdata <= wdata_i;
            lat_be    <= be_i;
            if (WAIT_CYCLES == 0) begin
              state <= DMEM_RESP;
            end else begin
              state <= DMEM_WAIT;
              cnt   <= 4'(WAIT_CYCLES - 1);
            end
          end else begin
            state <= DMEM_IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_resp.sv
// Bench for dmem_resp: three instances (0, 1, 3 wait states) against a queue/array model.
// Honours DMEM_ERR_EN the same way the design does.
module tb_dmem_resp;

  typedef struct {
    int          due;
    logic [31:0] rd;
    logic        er;
  } rsp_t;

  logic        clk = 1'b0;
  logic        rst [3];
  logic        req [3];
  logic        we  [3];
  logic [31:0] addr [3];
  logic [31:0] wdata [3];
  logic [3:0]  be [3];
  logic        gnt [3];
  logic        rvalid [3];
  logic [31:0] rdata [3];
  logic        err [3];
  logic        busy [3];

  int          cyc = 0;
  int          n_chk = 0;
  int          n_pass = 0;
  bit          mon_en = 0;
  bit          skip [3];
  rsp_t        exp_q [3][$];
  logic [31:0] mm [3][1024];
  logic [31:0] last_rd [3];
  logic        last_er [3];
  int          last_cyc [3];
  int          n_rv [3];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    dmem_resp #(.WAIT_CYCLES(g == 0 ? 0 : (g == 1 ? 1 : 3))) u_dut (
      .clk_i(clk), .rst_i(rst[g]), .req_i(req[g]), .we_i(we[g]), .addr_i(addr[g]),
      .wdata_i(wdata[g]), .be_i(be[g]), .gnt_o(gnt[g]), .rvalid_o(rvalid[g]),
      .rdata_o(rdata[g]), .err_o(err[g]), .busy_o(busy[g])
    );
  end

  function automatic int wc(input int k);
    return (k == 0) ? 0 : ((k == 1) ? 1 : 3);
  endfunction

  task automatic chk(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s[%0d] @cyc %0d: got %h, expected %h", name, k, cyc, act, exp);
  endtask

  // Reference: word index wraps modulo depth; errors only with the checking build.
  task automatic model(input int k, input logic w, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] b, output logic [31:0] rd, output logic er);
    int idx;
    idx = int'((a >> 2) % 1024);
    er = 1'b0;
`ifdef DMEM_ERR_EN
    er = (a >= 32'h1000) ||
         !(b inside {4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0011, 4'b1100, 4'b1111});
`endif
    rd = 32'h0;
    if (!er) begin
      if (w) begin
        for (int i = 0; i < 4; i++) if (b[i]) mm[k][idx][8*i +: 8] = d[8*i +: 8];
      end else begin
        rd = mm[k][idx];
      end
    end
  endtask

  task automatic do_req(input int k, input logic w, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] b, input bit hold, input bit use_model);
    logic [31:0] rd;
    logic        er;
    int          t;
    @(negedge clk);
    req[k] = 1'b1; we[k] = w; addr[k] = a; wdata[k] = d; be[k] = b;
    t = 0;
    while (!gnt[k] && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t >= 50) begin
      chk("grant_timeout", k, {31'b0, gnt[k]}, 32'h1);
      req[k] = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    if (use_model) begin
      model(k, w, a, d, b, rd, er);
      exp_q[k].push_back('{due: cyc + wc(k), rd: rd, er: er});
    end
    if (!hold) begin
      // Scramble the idle inputs so a design that samples late sees garbage.
      req[k] = 1'b0; we[k] = 1'($urandom); addr[k] = $urandom;
      wdata[k] = $urandom; be[k] = 4'($urandom);
    end
  endtask

  task automatic wait_done(input int k);
    int t;
    t = 0;
    while (exp_q[k].size() != 0 && t < 60) begin
      @(negedge clk);
      #1;
      t++;
    end
    if (exp_q[k].size() != 0) chk("drain_timeout", k, exp_q[k].size(), 32'h0);
  endtask

  task automatic do_reset(input int k, input int n);
    @(negedge clk);
    skip[k] = 1'b1;
    rst[k] = 1'b1;
    exp_q[k].delete();
    repeat (n) @(negedge clk);
    rst[k] = 1'b0;
    skip[k] = 1'b0;
  endtask

  task automatic rw(input int k, input logic w, input logic [31:0] a, input logic [31:0] d,
                    input logic [3:0] b);
    do_req(k, w, a, d, b, 1'b0, 1'b1);
    wait_done(k);
  endtask

  // Compare process: every cycle, gnt/busy against model occupancy, responses against the queue.
  always @(negedge clk) begin
    if (mon_en) begin
      for (int k = 0; k < 3; k++) begin
        bit   pend;
        rsp_t e;
        pend = (exp_q[k].size() != 0);
        if (!skip[k]) begin
          chk("gnt", k, {31'b0, gnt[k]}, {31'b0, !(pend && cyc < exp_q[k][0].due)});
          chk("busy", k, {31'b0, busy[k]}, {31'b0, pend});
        end
        if (rvalid[k]) begin
          if (!pend) begin
            chk("rvalid_unexpected", k, {31'b0, rvalid[k]}, 32'h0);
          end else begin
            e = exp_q[k].pop_front();
            chk("rsp_cycle", k, cyc, e.due);
            chk("rdata", k, rdata[k], e.rd);
            chk("err", k, {31'b0, err[k]}, {31'b0, e.er});
            last_rd[k] = rdata[k];
            last_er[k] = err[k];
            last_cyc[k] = cyc;
            n_rv[k]++;
          end
        end else if (pend && exp_q[k][0].due <= cyc) begin
          chk("rvalid_missing", k, {31'b0, rvalid[k]}, 32'h1);
          void'(exp_q[k].pop_front());
        end
      end
    end
  end

  logic [31:0] pool [7] = '{32'h0, 32'h10, 32'h14, 32'h3FC, 32'hFFC, 32'h1000, 32'h2010};

  initial begin
    int t0, n0;
    logic [31:0] a;
    logic        w;
    for (int k = 0; k < 3; k++) begin
      rst[k] = 1'b1; req[k] = 1'b0; we[k] = 1'b0; addr[k] = '0;
      wdata[k] = '0; be[k] = '0; skip[k] = 1'b0; n_rv[k] = 0;
    end
    repeat (3) @(negedge clk);
    for (int k = 0; k < 3; k++) rst[k] = 1'b0;
    mon_en = 1'b1;
    #1;
    for (int k = 0; k < 3; k++) begin
      chk("reset_rvalid", k, {31'b0, rvalid[k]}, 32'h0);
      chk("reset_err", k, {31'b0, err[k]}, 32'h0);
      chk("reset_rdata", k, rdata[k], 32'h0);
      chk("reset_busy", k, {31'b0, busy[k]}, 32'h0);
      chk("reset_gnt", k, {31'b0, gnt[k]}, 32'h1);
    end
    repeat (10) @(negedge clk);

    // Directed byte-lane sequence, one wait state.
    rw(1, 1'b1, 32'h10, 32'hDEADBEEF, 4'b1111);
    chk("store_rdata_zero", 1, last_rd[1], 32'h0);
    rw(1, 1'b0, 32'h10, 32'h0, 4'b0000);
    chk("load_word", 1, last_rd[1], 32'hDEADBEEF);
    rw(1, 1'b1, 32'h10, 32'h000000AA, 4'b0001);
    rw(1, 1'b0, 32'h10, 32'h0, 4'b1111);
    chk("load_after_byte", 1, last_rd[1], 32'hDEADBEAA);
    rw(1, 1'b1, 32'h10, 32'hCAFE0000, 4'b1100);
    rw(1, 1'b0, 32'h12, 32'h0, 4'b0001);
    chk("load_after_half", 1, last_rd[1], 32'hCAFEBEAA);
`ifdef DMEM_ERR_EN
    rw(1, 1'b0, 32'h1000, 32'h0, 4'b1111);
    chk("oob_err", 1, {31'b0, last_er[1]}, 32'h1);
    chk("oob_rdata", 1, last_rd[1], 32'h0);
    rw(1, 1'b1, 32'h10, 32'h55555555, 4'b0101);
    chk("bad_be_err", 1, {31'b0, last_er[1]}, 32'h1);
    rw(1, 1'b0, 32'h10, 32'h0, 4'b1111);
    chk("bad_be_nowrite", 1, last_rd[1], 32'hCAFEBEAA);
`else
    rw(1, 1'b1, 32'h1000, 32'h12345678, 4'b1111);
    rw(1, 1'b0, 32'h0, 32'h0, 4'b1111);
    chk("alias_0x1000", 1, last_rd[1], 32'h12345678);
`endif

    // Zero wait states: four loads back to back with req held.
    for (int i = 0; i < 4; i++) rw(0, 1'b1, 32'h100 + 4*i, 32'hA0 + i, 4'b1111);
    n0 = n_rv[0];
    do_req(0, 1'b0, 32'h100, 32'h0, 4'b1111, 1'b1, 1'b1);
    t0 = cyc;
    do_req(0, 1'b0, 32'h104, 32'h0, 4'b1111, 1'b1, 1'b1);
    do_req(0, 1'b0, 32'h108, 32'h0, 4'b1111, 1'b1, 1'b1);
    do_req(0, 1'b0, 32'h10C, 32'h0, 4'b1111, 1'b0, 1'b1);
    wait_done(0);
    chk("b2b_count", 0, n_rv[0] - n0, 32'd4);
    chk("b2b_span", 0, last_cyc[0] - t0, 32'd3);
    chk("b2b_last", 0, last_rd[0], 32'hA3);

    // Reset during wait states drops the store and its response.
    rw(2, 1'b1, 32'h40, 32'h11111111, 4'b1111);
    skip[2] = 1'b1;
    do_req(2, 1'b1, 32'h40, 32'h22222222, 4'b1111, 1'b0, 1'b0);
    do_reset(2, 2);
    repeat (6) @(negedge clk);
    rw(2, 1'b0, 32'h40, 32'h0, 4'b1111);
    chk("reset_drop_old", 2, last_rd[2], 32'h11111111);

    // Randomized traffic on every instance over a small aliasing address pool.
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 5; i++) do_req(k, 1'b1, pool[i], $urandom, 4'b1111, 1'b0, 1'b1);
      for (int i = 0; i < 40; i++) begin
        a = pool[$urandom_range(0, 6)] | 32'($urandom_range(0, 3));
        w = 1'($urandom_range(0, 1));
        do_req(k, w, a, $urandom, 4'($urandom), 1'b0, 1'b1);
        repeat ($urandom_range(0, 2)) @(negedge clk);
      end
      wait_done(k);
    end

    repeat (5) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/dmem_resp.md
# dmem_resp

Data-memory responder for the load/store path of the RV32 pipeline. The mem stage drives requests; this block answers them. It accepts one word-granular request per handshake, applies byte-enabled writes or performs word reads after a fixed number of wait states, and returns a single-cycle response. It replaces the combinational pass-through currently in the mem stage once loads and stores are wired in.

## Interface
- ADDR_WIDTH, 32, byte address width
- DATA_WIDTH, 32, data word width
- DEPTH_WORDS, 1024, memory depth in words, power of two
- WAIT_CYCLES, 1, wait states between accept and access, 0..15
- clk_i  in  1  clock; all state updates on rising edge
- rst_i  in  1  reset, synchronous, active-high
- req_i  in  1  request valid from mem stage
- we_i  in  1  1 = store, 0 = load
- addr_i  in  ADDR_WIDTH  byte address; bits [1:0] ignored for indexing
- wdata_i  in  DATA_WIDTH  store data, already lane-aligned
- be_i  in  4  byte enables, bit k = byte lane k
- gnt_o  out  1  request accepted this cycle when req_i && gnt_o
- rvalid_o  out  1  response valid, one cycle per accepted request
- rdata_o  out  DATA_WIDTH  full read word; 0 for stores and errors
- err_o  out  1  access error, qualified by rvalid_o
- busy_o  out  1  request in flight (state != IDLE)

## Operation
- FSM states: IDLE, WAIT, RESP.
- gnt_o = 1 in IDLE and RESP, 0 in WAIT. gnt_o is combinational from state only, never from req_i.
- Accept (req_i && gnt_o): latch we_i, addr_i, wdata_i, be_i. Next state is WAIT with cnt = WAIT_CYCLES-1, or RESP if WAIT_CYCLES == 0.
- WAIT: cnt decrements each cycle. When cnt == 0, next state is RESP.
- Access commits on the edge entering RESP:
  - store: bytes with be set are written; other bytes unchanged; rdata_o = 0.
  - load: rdata_o = mem[index], ignoring be.
- RESP: rvalid_o = 1 for exactly one cycle. With a new accept in the same cycle, go to WAIT/RESP; otherwise go to IDLE.
- Index = addr_i[log2(DEPTH_WORDS)+1:2].
- Load-after-store to the same word returns the stored data; there is no bypass hazard because accesses are serialized.
- Inputs are ignored while gnt_o = 0. The requester holds req_i until granted.

## Timing
- Reset values: state IDLE, cnt 0, rvalid_o 0, rdata_o 0, err_o 0, busy_o 0, gnt_o 1 (after reset deasserts). Memory contents are not reset.
- Latency: accept in cycle N gives rvalid_o in cycle N+1+WAIT_CYCLES.
- Throughput: one request per WAIT_CYCLES+1 cycles. With WAIT_CYCLES = 0 it is one per cycle, back-to-back.
- Reset asserted while in WAIT or RESP: the pending request is dropped and no response is given. A store is not committed if rst_i is high on the commit edge.
- rst_i has priority over accept on the same edge.
- rdata_o/err_o hold their value outside rvalid_o; consumers qualify them with rvalid_o.

## Configuration
- Macro DMEM_ERR_EN.
- Defined: an access is an error when the address is out of range (addr_i >= 4*DEPTH_WORDS) or be_i is not one of 0001, 0010, 0100, 1000, 0011, 1100, 1111. On error: no write, rdata_o = 0, err_o = 1 with rvalid_o, same latency as a normal access.
- Undefined: the index wraps modulo DEPTH_WORDS, be_i is applied as given, and err_o is tied to 0.

## Structure
- defines.v gains:
  - FSM state encodings (DMEM_IDLE, DMEM_WAIT, DMEM_RESP)
  - legal byte-enable pattern constants
  - a BE_WIDTH constant (4)
- Existing DATA_WIDTH/ADDR_WIDTH defines supply the parameter defaults.
- Sub-module dmem_ram: single-port, byte-writable synchronous array (clk_i, we, be, index, wdata, rdata), no reset. dmem_resp owns the FSM, counter, error check and output registers.

## Test plan
- Reset, then idle: gnt_o = 1, rvalid_o = 0, busy_o = 0, err_o = 0 for 10 cycles.
- WAIT_CYCLES = 1: store 0xDEADBEEF, be 1111 to 0x10 at cycle N -> rvalid_o at N+2 with rdata_o = 0; then load 0x10 -> rdata_o = 0xDEADBEEF.
- Byte store 0x000000AA, be 0001 to 0x10 over 0xDEADBEEF -> load returns 0xDEADBEAA. Halfword 0xCAFE0000, be 1100 -> 0xCAFEBEAA.
- WAIT_CYCLES = 0: four back-to-back loads with req_i held high -> four consecutive rvalid_o cycles with gnt_o constantly 1.
- DMEM_ERR_EN: load 0x1000 (DEPTH 1024) -> err_o = 1, rdata_o = 0. Store with be 0101 -> err_o = 1 and memory unchanged on readback. Without the macro, 0x1000 aliases to 0x0.
- Store accepted at N, rst_i high at N+1 (WAIT_CYCLES = 3) -> no rvalid_o is ever produced, and a load of that address after reset returns the old data.
